// File: rtl/gate_pair_sequencer_if.sv
// Test-vector stream into the gate-pair sequencer: one {b, c, b1, c1} vector per valid/ready handshake.
interface gate_pair_sequencer_if;
  typedef struct packed {
    logic b;
    logic c;
    logic b1;
    logic c1;
  } vec_t;

  logic vec_valid;
  logic vec_ready;
  vec_t vec_data;
  logic vec_last;

  modport master (output vec_valid, output vec_data, output vec_last, input vec_ready);
  modport slave  (input vec_valid, input vec_data, input vec_last, output vec_ready);
endinterface

// File: rtl/gate_pair_sequencer.sv
// Drives vectors into the AND/OR gate-pair cell, waits SETTLE_CYC, samples and checks a/a1.
// Latency: handshake cycle to res_valid = SETTLE_CYC+2 cycles; one vector per SETTLE_CYC+3 cycles.
// Backpressure: vec_ready only in FETCH; abort returns to IDLE from any busy state.
module gate_pair_sequencer #(
  parameter int SETTLE_CYC = 4,
  parameter int CNT_W      = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  gate_pair_sequencer_if.slave vec,
  output logic                 drv_b,
  output logic                 drv_c,
  output logic                 drv_b1,
  output logic                 drv_c1,
  input  logic                 dut_a,
  input  logic                 dut_a1,
  output logic                 res_valid,
  output logic                 res_a,
  output logic                 res_a1,
  output logic                 res_match,
  output logic                 busy,
  output logic                 done,
  output logic [CNT_W-1:0]     vec_cnt,
  output logic [CNT_W-1:0]     err_cnt
);
  localparam int TMR_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  typedef enum logic [2:0] {IDLE, FETCH, SETTLE, SAMPLE, REPORT, DONE} state_t;

  state_t           state;
  logic [TMR_W-1:0] timer;
  logic             last_q;
  logic             cell_ok;

  // drv_* hold the accepted vector until the next acceptance, so they double as the reference.
  assign cell_ok = (dut_a == (drv_b & drv_c)) && (dut_a1 == (drv_b1 | drv_c1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      timer         <= '0;
      last_q        <= 1'b0;
      vec.vec_ready <= 1'b0;
      drv_b         <= 1'b0;
      drv_c         <= 1'b0;
      drv_b1        <= 1'b0;
      drv_c1        <= 1'b0;
      res_valid     <= 1'b0;
      res_a         <= 1'b0;
      res_a1        <= 1'b0;
      res_match     <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      vec_cnt       <= '0;
      err_cnt       <= '0;
    end else begin
      res_valid <= 1'b0;
      done      <= 1'b0;
      if (abort && state != IDLE) begin
        state         <= IDLE;
        vec.vec_ready <= 1'b0;
        busy          <= 1'b0;
        {drv_b, drv_c, drv_b1, drv_c1} <= 4'b0000;
      end else begin
        case (state)
          IDLE: begin
            if (start && !abort) begin
              state         <= FETCH;
              vec.vec_ready <= 1'b1;
              busy          <= 1'b1;
              vec_cnt       <= '0;
              err_cnt       <= '0;
              res_a         <= 1'b0;
              res_a1        <= 1'b0;
              res_match     <= 1'b0;
            end
          end
          FETCH: begin
            if (vec.vec_valid && vec.vec_ready) begin
              {drv_b, drv_c, drv_b1, drv_c1} <= vec.vec_data;
              last_q        <= vec.vec_last;
              timer         <= TMR_W'(SETTLE_CYC - 1);
              vec.vec_ready <= 1'b0;
              state         <= SETTLE;
            end
          end
          SETTLE: begin
            if (timer == '0) state <= SAMPLE;
            else             timer <= timer - TMR_W'(1);
          end
          SAMPLE: begin
            res_a     <= dut_a;
            res_a1    <= dut_a1;
            res_match <= cell_ok;
            vec_cnt   <= vec_cnt + CNT_W'(1);
            if (!cell_ok && err_cnt != {CNT_W{1'b1}}) err_cnt <= err_cnt + CNT_W'(1);
            res_valid <= 1'b1;
            state     <= REPORT;
          end
          REPORT: begin
            if (last_q) begin
              done  <= 1'b1;
              state <= DONE;
            end else begin
              vec.vec_ready <= 1'b1;
              state         <= FETCH;
            end
          end
          DONE: begin
            busy  <= 1'b0;
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_gate_pair_sequencer.sv
// Bench for gate_pair_sequencer: three instances (settle 4/1/2, counter width 8/8/2) with a behavioural cell model each.
`timescale 1ns/1ps
module tb_gate_pair_sequencer;
  localparam int NI = 3;
  localparam int S0 = 4;
  localparam int S1 = 1;
  localparam int S2 = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [NI-1:0] start, abort, vec_valid, vec_last, stuck0, a1_inv;
  logic [NI-1:0][3:0] vec_data;
  int rise_dly [NI];
  logic [NI-1:0] vec_ready, drv_b, drv_c, drv_b1, drv_c1, dut_a, dut_a1;
  logic [NI-1:0] res_valid, res_a, res_a1, res_match, busy, done;
  logic [NI-1:0][7:0] vec_cnt, err_cnt;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int S = (g == 0) ? S0 : ((g == 1) ? S1 : S2);
    localparam int W = (g == 2) ? 2 : 8;
    gate_pair_sequencer_if vif ();
    logic [W-1:0] vc, ec;
    int rcnt = 0;

    assign vif.vec_valid = vec_valid[g];
    assign vif.vec_data  = vec_data[g];
    assign vif.vec_last  = vec_last[g];
    assign vec_ready[g]  = vif.vec_ready;
    assign vec_cnt[g]    = 8'(vc);
    assign err_cnt[g]    = 8'(ec);

    // Cell: a rises only after b&c has been high for rise_dly edges, falls at once.
    always @(posedge clk) rcnt <= (drv_b[g] & drv_c[g]) ? ((rcnt < 1000) ? rcnt + 1 : rcnt) : 0;
    assign dut_a[g]  = !stuck0[g] && drv_b[g] && drv_c[g] && (rcnt >= rise_dly[g]);
    assign dut_a1[g] = (drv_b1[g] | drv_c1[g]) ^ a1_inv[g];

    gate_pair_sequencer #(.SETTLE_CYC(S), .CNT_W(W)) u_dut (
      .clk(clk), .rst(rst), .start(start[g]), .abort(abort[g]), .vec(vif.slave),
      .drv_b(drv_b[g]), .drv_c(drv_c[g]), .drv_b1(drv_b1[g]), .drv_c1(drv_c1[g]),
      .dut_a(dut_a[g]), .dut_a1(dut_a1[g]),
      .res_valid(res_valid[g]), .res_a(res_a[g]), .res_a1(res_a1[g]), .res_match(res_match[g]),
      .busy(busy[g]), .done(done[g]), .vec_cnt(vc), .err_cnt(ec)
    );
  end

  task automatic do_reset();
    rst = 1'b1;
    start = '0; abort = '0; vec_valid = '0; vec_last = '0; vec_data = '0;
    stuck0 = '0; a1_inv = '0;
    for (int i = 0; i < NI; i++) rise_dly[i] = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic start_run(input int i);
    int n = 0;
    while (busy[i] && n < 30) begin @(negedge clk); n++; end
    start[i] = 1'b1;
    @(negedge clk);
    start[i] = 1'b0;
  endtask

  // lat counts cycles from the handshake cycle (cycle 0) to the cycle with res_valid; -1 on timeout.
  task automatic send_vec(input int i, input logic [3:0] d, input logic last, output int lat,
                          output logic ra, output logic ra1, output logic rm,
                          output logic rv2, output logic dn);
    int n = 0;
    lat = -1; ra = 1'b0; ra1 = 1'b0; rm = 1'b0; rv2 = 1'b1; dn = 1'b0;
    while (!vec_ready[i] && n < 40) begin @(negedge clk); n++; end
    if (!vec_ready[i]) return;
    vec_valid[i] = 1'b1; vec_data[i] = d; vec_last[i] = last;
    @(negedge clk);
    vec_valid[i] = 1'b0; vec_data[i] = 4'($urandom); vec_last[i] = 1'($urandom);
    n = 1;
    while (!res_valid[i] && n < 40) begin @(negedge clk); n++; end
    if (!res_valid[i]) return;
    lat = n; ra = res_a[i]; ra1 = res_a1[i]; rm = res_match[i];
    @(negedge clk);
    rv2 = res_valid[i]; dn = done[i];
  endtask

  task automatic test_reset();
    do_reset();
    for (int i = 0; i < NI; i++) begin
      checks++;
      if ({vec_ready[i], drv_b[i], drv_c[i], drv_b1[i], drv_c1[i], res_valid[i], res_a[i],
           res_a1[i], res_match[i], busy[i], done[i]} !== 11'b0)
        begin errors++; $display("FAIL reset_bits[%0d]: got %b expected all zero", i,
          {vec_ready[i], drv_b[i], drv_c[i], drv_b1[i], drv_c1[i], res_valid[i], res_a[i],
           res_a1[i], res_match[i], busy[i], done[i]}); end
      checks++;
      if (vec_cnt[i] !== 8'd0 || err_cnt[i] !== 8'd0)
        begin errors++; $display("FAIL reset_cnt[%0d]: got %0d/%0d expected 0/0", i, vec_cnt[i], err_cnt[i]); end
    end
  endtask

  task automatic test_basic();
    int lat; logic ra, ra1, rm, rv2, dn;
    logic [3:0] vecs [2] = '{4'b1011, 4'b1100};
    start_run(0);
    checks++;
    if (busy[0] !== 1'b1 || vec_ready[0] !== 1'b1)
      begin errors++; $display("FAIL basic_fetch: got busy=%b ready=%b expected 1/1", busy[0], vec_ready[0]); end
    for (int k = 0; k < 2; k++) begin
      send_vec(0, vecs[k], 1'(k == 1), lat, ra, ra1, rm, rv2, dn);
      checks++;
      if (lat !== S0 + 2) begin errors++; $display("FAIL basic_lat: got %0d expected %0d", lat, S0 + 2); end
      checks++;
      if ({ra, ra1, rm} !== {vecs[k][3] & vecs[k][2], vecs[k][1] | vecs[k][0], 1'b1})
        begin errors++; $display("FAIL basic_res: got %b expected %b", {ra, ra1, rm},
          {vecs[k][3] & vecs[k][2], vecs[k][1] | vecs[k][0], 1'b1}); end
      checks++;
      if ({rv2, dn} !== {1'b0, 1'(k == 1)})
        begin errors++; $display("FAIL basic_strobes: got %b expected %b", {rv2, dn}, {1'b0, 1'(k == 1)}); end
    end
    checks++;
    if (vec_cnt[0] !== 8'd2 || err_cnt[0] !== 8'd0)
      begin errors++; $display("FAIL basic_cnt: got %0d/%0d expected 2/0", vec_cnt[0], err_cnt[0]); end
    @(negedge clk);
    checks++;
    if (busy[0] !== 1'b0) begin errors++; $display("FAIL basic_idle: got busy=%b expected 0", busy[0]); end
  endtask

  task automatic test_stuck();
    int lat; logic ra, ra1, rm, rv2, dn;
    stuck0[0] = 1'b1;
    start_run(0);
    send_vec(0, 4'b1100, 1'b1, lat, ra, ra1, rm, rv2, dn);
    checks++;
    if ({ra, rm, dn} !== 3'b001 || err_cnt[0] !== 8'd1 || vec_cnt[0] !== 8'd1)
      begin errors++; $display("FAIL stuck: got a/match/done=%b err=%0d vec=%0d expected 001 1 1",
        {ra, rm, dn}, err_cnt[0], vec_cnt[0]); end
    stuck0[0] = 1'b0;
  endtask

  task automatic test_rise_delay();
    int lat; logic ra, ra1, rm, rv2, dn;
    do_reset();
    rise_dly[1] = 2; rise_dly[0] = 2;
    start_run(1);
    send_vec(1, 4'b1100, 1'b1, lat, ra, ra1, rm, rv2, dn);
    checks++;
    if (lat !== S1 + 2 || {ra, rm} !== 2'b00 || err_cnt[1] !== 8'd1)
      begin errors++; $display("FAIL rise_short: got lat=%0d a/match=%b err=%0d expected %0d 00 1",
        lat, {ra, rm}, err_cnt[1], S1 + 2); end
    start_run(0);
    send_vec(0, 4'b1100, 1'b1, lat, ra, ra1, rm, rv2, dn);
    checks++;
    if (lat !== S0 + 2 || {ra, rm} !== 2'b11 || err_cnt[0] !== 8'd0)
      begin errors++; $display("FAIL rise_long: got lat=%0d a/match=%b err=%0d expected %0d 11 0",
        lat, {ra, rm}, err_cnt[0], S0 + 2); end
    rise_dly[1] = 0; rise_dly[0] = 0;
  endtask

  task automatic test_abort();
    int lat, strobes, n; logic ra, ra1, rm, rv2, dn;
    start_run(0);
    send_vec(0, 4'b0101, 1'b0, lat, ra, ra1, rm, rv2, dn);
    n = 0;
    while (!vec_ready[0] && n < 40) begin @(negedge clk); n++; end
    vec_valid[0] = 1'b1; vec_data[0] = 4'b1111; vec_last[0] = 1'b1;
    @(negedge clk);
    vec_valid[0] = 1'b0;
    checks++;
    if ({drv_b[0], drv_c[0], drv_b1[0], drv_c1[0]} !== 4'b1111)
      begin errors++; $display("FAIL abort_drv_before: got %b expected 1111", {drv_b[0], drv_c[0], drv_b1[0], drv_c1[0]}); end
    @(negedge clk);
    abort[0] = 1'b1;
    @(negedge clk);
    abort[0] = 1'b0;
    checks++;
    if ({busy[0], vec_ready[0], drv_b[0], drv_c[0], drv_b1[0], drv_c1[0]} !== 6'b0)
      begin errors++; $display("FAIL abort_state: got %b expected 000000",
        {busy[0], vec_ready[0], drv_b[0], drv_c[0], drv_b1[0], drv_c1[0]}); end
    strobes = 0;
    for (int k = 0; k < 12; k++) begin
      strobes += int'(res_valid[0]) + int'(done[0]);
      @(negedge clk);
    end
    checks++;
    if (strobes !== 0 || vec_cnt[0] !== 8'd1 || err_cnt[0] !== 8'd0)
      begin errors++; $display("FAIL abort_after: got strobes=%0d vec=%0d err=%0d expected 0 1 0",
        strobes, vec_cnt[0], err_cnt[0]); end
    start[0] = 1'b1; abort[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0; abort[0] = 1'b0;
    checks++;
    if (busy[0] !== 1'b0 || vec_cnt[0] !== 8'd1)
      begin errors++; $display("FAIL abort_vs_start: got busy=%b vec=%0d expected 0 1", busy[0], vec_cnt[0]); end
  endtask

  task automatic test_saturate();
    int lat; logic ra, ra1, rm, rv2, dn;
    stuck0[2] = 1'b1;
    start_run(2);
    for (int k = 1; k <= 5; k++) begin
      send_vec(2, {2'b11, 2'($urandom)}, 1'(k == 5), lat, ra, ra1, rm, rv2, dn);
      checks++;
      if (lat !== S2 + 2 || rm !== 1'b0)
        begin errors++; $display("FAIL sat_vec%0d: got lat=%0d match=%b expected %0d 0", k, lat, rm, S2 + 2); end
      checks++;
      if (vec_cnt[2] !== 8'(k % 4) || err_cnt[2] !== 8'((k < 3) ? k : 3))
        begin errors++; $display("FAIL sat_cnt%0d: got %0d/%0d expected %0d/%0d", k, vec_cnt[2], err_cnt[2],
          k % 4, (k < 3) ? k : 3); end
    end
    checks++;
    if (dn !== 1'b1) begin errors++; $display("FAIL sat_done: got %b expected 1", dn); end
    stuck0[2] = 1'b0;
  endtask

  task automatic test_stall();
    int lat; logic ra, ra1, rm, rv2, dn;
    start_run(0);
    send_vec(0, 4'b0110, 1'b0, lat, ra, ra1, rm, rv2, dn);
    for (int k = 0; k < 10; k++) begin
      checks++;
      if ({vec_ready[0], busy[0]} !== 2'b11 || vec_cnt[0] !== 8'd1 || res_valid[0] !== 1'b0)
        begin errors++; $display("FAIL stall_c%0d: got ready/busy=%b vec=%0d rv=%b expected 11 1 0",
          k, {vec_ready[0], busy[0]}, vec_cnt[0], res_valid[0]); end
      vec_data[0] = 4'($urandom); vec_last[0] = 1'($urandom); start[0] = 1'(k == 4);
      @(negedge clk);
    end
    start[0] = 1'b0;
    send_vec(0, 4'b1111, 1'b1, lat, ra, ra1, rm, rv2, dn);
    checks++;
    if (vec_cnt[0] !== 8'd2 || {rm, dn} !== 2'b11)
      begin errors++; $display("FAIL stall_end: got vec=%0d match/done=%b expected 2 11", vec_cnt[0], {rm, dn}); end
  endtask

  task automatic test_back_to_back();
    int lat, len, n, errs; logic ra, ra1, rm, rv2, dn, ea, ea1, em;
    logic [3:0] d;
    for (int r = 0; r < 3; r++) begin
      len = $urandom_range(1, 6); n = 0; errs = 0;
      start_run(0);
      for (int k = 0; k < len; k++) begin
        d = 4'($urandom);
        stuck0[0] = ($urandom_range(0, 3) == 0);
        a1_inv[0] = ($urandom_range(0, 3) == 0);
        ea  = !stuck0[0] && d[3] && d[2];
        ea1 = (d[1] | d[0]) ^ a1_inv[0];
        em  = (ea == (d[3] & d[2])) && (ea1 == (d[1] | d[0]));
        n++;
        if (!em) errs = (errs < 255) ? errs + 1 : 255;
        send_vec(0, d, 1'(k == len - 1), lat, ra, ra1, rm, rv2, dn);
        checks++;
        if (lat !== S0 + 2 || {ra, ra1, rm} !== {ea, ea1, em})
          begin errors++; $display("FAIL rand_r%0d_v%0d: got lat=%0d res=%b expected %0d %b", r, k, lat,
            {ra, ra1, rm}, S0 + 2, {ea, ea1, em}); end
        checks++;
        if (vec_cnt[0] !== 8'(n) || err_cnt[0] !== 8'(errs) || dn !== 1'(k == len - 1))
          begin errors++; $display("FAIL rand_cnt_r%0d_v%0d: got %0d/%0d done=%b expected %0d/%0d %b", r, k,
            vec_cnt[0], err_cnt[0], dn, n, errs, 1'(k == len - 1)); end
      end
    end
    stuck0[0] = 1'b0; a1_inv[0] = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stuck();
    test_rise_delay();
    test_abort();
    test_saturate();
    test_stall();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within 200000 ns");
    $fatal(1);
  end
endmodule
